// File: rtl/jk_pkg.sv
// Shared types and helpers for the jk_flop_bank register cell.
//   jk_mode_e  : next-state rule selector shared by every bit of the bank
//   CNT_DEF_W  : default width of the transition counter
//   popcount   : number of set bits in a vector of up to POP_MAX_W bits
package jk_pkg;

  typedef enum logic [1:0] {
    JK_MODE_JK = 2'b00,
    JK_MODE_D  = 2'b01,
    JK_MODE_T  = 2'b10,
    JK_MODE_SR = 2'b11
  } jk_mode_e;

  localparam int unsigned CNT_DEF_W = 16;
  localparam int unsigned POP_MAX_W = 64;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POP_MAX_W; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/jk_flop_bank_if.sv
// Signal bundle for jk_flop_bank.
//   master : drives en/mode/j/k/sync_clr/load/load_val/cnt_clr, observes outputs
//   slave  : the flop bank itself; drives q/q_n/rise/fall/sr_conflict/toggle_cnt
interface jk_flop_bank_if
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = CNT_DEF_W
);

  logic             en;
  jk_mode_e         mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             sync_clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             cnt_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             sr_conflict;
  logic [CNT_W-1:0] toggle_cnt;

  modport master (
    output en, mode, j, k, sync_clr, load, load_val, cnt_clr,
    input  q, q_n, rise, fall, sr_conflict, toggle_cnt
  );

  modport slave (
    input  en, mode, j, k, sync_clr, load, load_val, cnt_clr,
    output q, q_n, rise, fall, sr_conflict, toggle_cnt
  );

endinterface

// File: rtl/jk_cell_next.sv
// Combinational next-state rule for one flip-flop bit.
//   mode     : JK / D / T / SR rule
//   j, k     : J/D/T/S and K/-/-/R inputs
//   q        : current state
//   q_next   : state the rule would write
//   conflict : S=R=1 seen in SR mode (bit holds)
module jk_cell_next
  import jk_pkg::*;
(
  input  jk_mode_e mode,
  input  logic     j,
  input  logic     k,
  input  logic     q,
  output logic     q_next,
  output logic     conflict
);

  always_comb begin
    q_next   = q;
    conflict = 1'b0;
    case (mode)
      JK_MODE_JK: begin
        case ({j, k})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          2'b11:   q_next = ~q;
          default: q_next = q;
        endcase
      end
      JK_MODE_D: q_next = j;
      JK_MODE_T: q_next = j ? ~q : q;
      JK_MODE_SR: begin
        if (j && !k)      q_next = 1'b1;
        else if (!j && k) q_next = 1'b0;
        conflict = j & k;
      end
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/jk_flop_bank.sv
// WIDTH-bit bank of independent flip-flops sharing one mode rule, with
// synchronous clear, parallel load, edge pulses, SR-conflict flag and a
// saturating bit-transition counter.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus        : jk_flop_bank_if slave (controls in, q/q_n/rise/fall/
//                sr_conflict/toggle_cnt out)
module jk_flop_bank
  import jk_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      CNT_W     = CNT_DEF_W
) (
  input  logic            clk,
  input  logic            reset,
  jk_flop_bank_if.slave   bus
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             sr_conflict;
  logic [CNT_W-1:0] toggle_cnt;

  logic [WIDTH-1:0] rule_next;
  logic [WIDTH-1:0] cell_conflict;
  logic [WIDTH-1:0] q_next;
  logic             conflict_next;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell_next u_cell (
      .mode     (bus.mode),
      .j        (bus.j[i]),
      .k        (bus.k[i]),
      .q        (q[i]),
      .q_next   (rule_next[i]),
      .conflict (cell_conflict[i])
    );
  end

  always_comb begin
    conflict_next = 1'b0;
    if (bus.sync_clr) begin
      q_next = RESET_VAL;
    end else if (bus.load) begin
      q_next = bus.load_val;
    end else if (bus.en) begin
      q_next        = rule_next;
      conflict_next = |cell_conflict;
    end else begin
      q_next = q;
    end

    // One guard bit: both operands fit in CNT_W bits, so a set top bit means
    // the true sum exceeded the counter range and must clamp.
    cnt_sum = {1'b0, toggle_cnt}
            + (CNT_W+1)'(popcount(POP_MAX_W'(q ^ q_next)));
    cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q           <= RESET_VAL;
      rise        <= '0;
      fall        <= '0;
      sr_conflict <= 1'b0;
      toggle_cnt  <= '0;
    end else begin
      q           <= q_next;
      rise        <= q_next & ~q;
      fall        <= ~q_next & q;
      sr_conflict <= conflict_next;
      toggle_cnt  <= bus.cnt_clr ? '0 : cnt_next;
    end
  end

  assign bus.q           = q;
  assign bus.q_n         = ~q;
  assign bus.rise        = rise;
  assign bus.fall        = fall;
  assign bus.sr_conflict = sr_conflict;
  assign bus.toggle_cnt  = toggle_cnt;

endmodule

// File: tb/tb_jk_flop_bank.sv
module tb_jk_flop_bank;
  import jk_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  jk_flop_bank_if #(.WIDTH(8), .CNT_W(16)) bus_a ();
  jk_flop_bank_if #(.WIDTH(8), .CNT_W(4))  bus_b ();

  jk_flop_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(16)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  jk_flop_bank #(.WIDTH(8), .RESET_VAL(8'h00), .CNT_W(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a;
    bus_a.en = 1'b0; bus_a.mode = JK_MODE_JK; bus_a.j = '0; bus_a.k = '0;
    bus_a.sync_clr = 1'b0; bus_a.load = 1'b0; bus_a.load_val = '0; bus_a.cnt_clr = 1'b0;
  endtask

  task automatic test_reset;
    idle_a;
    bus_b.en = 1'b0; bus_b.mode = JK_MODE_JK; bus_b.j = '0; bus_b.k = '0;
    bus_b.sync_clr = 1'b0; bus_b.load = 1'b0; bus_b.load_val = '0; bus_b.cnt_clr = 1'b0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    total++; if (bus_a.q !== 8'hA5) begin bad++; $display("FAIL reset_q got=%h exp=a5", bus_a.q); end
    total++; if (bus_a.q_n !== 8'h5A) begin bad++; $display("FAIL reset_qn got=%h exp=5a", bus_a.q_n); end
    total++; if (bus_a.rise !== 8'h00 || bus_a.fall !== 8'h00) begin bad++; $display("FAIL reset_edges rise=%h fall=%h exp=00/00", bus_a.rise, bus_a.fall); end
    total++; if (bus_a.toggle_cnt !== 16'd0 || bus_a.sr_conflict !== 1'b0) begin bad++; $display("FAIL reset_cnt cnt=%0d sr=%b exp=0/0", bus_a.toggle_cnt, bus_a.sr_conflict); end
    total++; if (bus_b.q !== 8'h00 || bus_b.toggle_cnt !== 4'd0) begin bad++; $display("FAIL reset_b q=%h cnt=%0d exp=00/0", bus_b.q, bus_b.toggle_cnt); end
    tick; tick;
    reset = 1'b0;
    tick;
    total++; if (bus_a.q !== 8'hA5) begin bad++; $display("FAIL reset_hold got=%h exp=a5", bus_a.q); end
  endtask

  task automatic test_jk;
    // bring q to 00 and clear the count in the same edge
    idle_a; bus_a.load = 1'b1; bus_a.load_val = 8'h00; bus_a.cnt_clr = 1'b1;
    tick;
    total++; if (bus_a.q !== 8'h00 || bus_a.fall !== 8'hA5 || bus_a.toggle_cnt !== 16'd0) begin bad++; $display("FAIL jk_prep q=%h fall=%h cnt=%0d exp=00/a5/0", bus_a.q, bus_a.fall, bus_a.toggle_cnt); end
    idle_a; bus_a.en = 1'b1; bus_a.mode = JK_MODE_JK; bus_a.j = 8'hFF; bus_a.k = 8'h00;
    tick;
    total++; if (bus_a.q !== 8'hFF || bus_a.rise !== 8'hFF || bus_a.toggle_cnt !== 16'd8) begin bad++; $display("FAIL jk_set q=%h rise=%h cnt=%0d exp=ff/ff/8", bus_a.q, bus_a.rise, bus_a.toggle_cnt); end
    bus_a.j = 8'hFF; bus_a.k = 8'hFF;
    tick;
    total++; if (bus_a.q !== 8'h00 || bus_a.fall !== 8'hFF || bus_a.rise !== 8'h00 || bus_a.toggle_cnt !== 16'd16) begin bad++; $display("FAIL jk_toggle q=%h rise=%h fall=%h cnt=%0d exp=00/00/ff/16", bus_a.q, bus_a.rise, bus_a.fall, bus_a.toggle_cnt); end
    bus_a.j = 8'h00; bus_a.k = 8'h00;
    tick;
    total++; if (bus_a.q !== 8'h00 || bus_a.rise !== 8'h00 || bus_a.fall !== 8'h00 || bus_a.toggle_cnt !== 16'd16) begin bad++; $display("FAIL jk_hold q=%h rise=%h fall=%h cnt=%0d exp=00/00/00/16", bus_a.q, bus_a.rise, bus_a.fall, bus_a.toggle_cnt); end
    bus_a.j = 8'hA0; bus_a.k = 8'h0A;
    tick;
    total++; if (bus_a.q !== 8'hA0 || bus_a.toggle_cnt !== 16'd18) begin bad++; $display("FAIL jk_mixed q=%h cnt=%0d exp=a0/18", bus_a.q, bus_a.toggle_cnt); end
    bus_a.j = 8'h00; bus_a.k = 8'hA0;
    tick;
    total++; if (bus_a.q !== 8'h00 || bus_a.toggle_cnt !== 16'd20) begin bad++; $display("FAIL jk_reset q=%h cnt=%0d exp=00/20", bus_a.q, bus_a.toggle_cnt); end
  endtask

  task automatic test_sr;
    idle_a; bus_a.load = 1'b1; bus_a.load_val = 8'h0F;
    tick;
    total++; if (bus_a.q !== 8'h0F || bus_a.toggle_cnt !== 16'd24) begin bad++; $display("FAIL sr_prep q=%h cnt=%0d exp=0f/24", bus_a.q, bus_a.toggle_cnt); end
    idle_a; bus_a.en = 1'b1; bus_a.mode = JK_MODE_SR; bus_a.j = 8'hF0; bus_a.k = 8'h0F;
    tick;
    total++; if (bus_a.q !== 8'hF0 || bus_a.rise !== 8'hF0 || bus_a.fall !== 8'h0F || bus_a.toggle_cnt !== 16'd32 || bus_a.sr_conflict !== 1'b0) begin bad++; $display("FAIL sr_swap q=%h rise=%h fall=%h cnt=%0d sr=%b exp=f0/f0/0f/32/0", bus_a.q, bus_a.rise, bus_a.fall, bus_a.toggle_cnt, bus_a.sr_conflict); end
    bus_a.j = 8'h01; bus_a.k = 8'h01;
    tick;
    total++; if (bus_a.q !== 8'hF0 || bus_a.sr_conflict !== 1'b1 || bus_a.toggle_cnt !== 16'd32) begin bad++; $display("FAIL sr_conflict q=%h sr=%b cnt=%0d exp=f0/1/32", bus_a.q, bus_a.sr_conflict, bus_a.toggle_cnt); end
    bus_a.en = 1'b0;
    tick;
    total++; if (bus_a.sr_conflict !== 1'b0 || bus_a.q !== 8'hF0) begin bad++; $display("FAIL sr_en_off sr=%b q=%h exp=0/f0", bus_a.sr_conflict, bus_a.q); end
    bus_a.en = 1'b1; bus_a.load = 1'b1; bus_a.load_val = 8'hF0;
    tick;
    total++; if (bus_a.sr_conflict !== 1'b0 || bus_a.q !== 8'hF0) begin bad++; $display("FAIL sr_load_masks sr=%b q=%h exp=0/f0", bus_a.sr_conflict, bus_a.q); end
  endtask

  task automatic test_priority;
    idle_a; bus_a.load = 1'b1; bus_a.load_val = 8'h00;
    tick;
    total++; if (bus_a.q !== 8'h00 || bus_a.toggle_cnt !== 16'd36) begin bad++; $display("FAIL pri_prep q=%h cnt=%0d exp=00/36", bus_a.q, bus_a.toggle_cnt); end
    idle_a; bus_a.sync_clr = 1'b1; bus_a.load = 1'b1; bus_a.load_val = 8'h3C;
    bus_a.en = 1'b1; bus_a.mode = JK_MODE_T; bus_a.j = 8'hFF;
    tick;
    total++; if (bus_a.q !== 8'hA5 || bus_a.rise !== 8'hA5 || bus_a.toggle_cnt !== 16'd40) begin bad++; $display("FAIL pri_clr q=%h rise=%h cnt=%0d exp=a5/a5/40", bus_a.q, bus_a.rise, bus_a.toggle_cnt); end
    idle_a; bus_a.load = 1'b1; bus_a.load_val = 8'h3C;
    tick;
    total++; if (bus_a.q !== 8'h3C || bus_a.rise !== 8'h18 || bus_a.fall !== 8'h81 || bus_a.toggle_cnt !== 16'd44) begin bad++; $display("FAIL pri_load q=%h rise=%h fall=%h cnt=%0d exp=3c/18/81/44", bus_a.q, bus_a.rise, bus_a.fall, bus_a.toggle_cnt); end
    idle_a; bus_a.mode = JK_MODE_D; bus_a.j = 8'h81; bus_a.en = 1'b0;
    tick;
    total++; if (bus_a.q !== 8'h3C || bus_a.rise !== 8'h00 || bus_a.fall !== 8'h00 || bus_a.toggle_cnt !== 16'd44) begin bad++; $display("FAIL pri_en_off q=%h rise=%h fall=%h cnt=%0d exp=3c/00/00/44", bus_a.q, bus_a.rise, bus_a.fall, bus_a.toggle_cnt); end
  endtask

  task automatic test_mode_switch;
    idle_a; bus_a.en = 1'b1; bus_a.mode = JK_MODE_D; bus_a.j = 8'h3C;
    tick;
    total++; if (bus_a.q !== 8'h3C) begin bad++; $display("FAIL sw_d q=%h exp=3c", bus_a.q); end
    bus_a.mode = JK_MODE_T; bus_a.j = 8'h01;
    tick;
    total++; if (bus_a.q !== 8'h3D || bus_a.rise !== 8'h01 || bus_a.toggle_cnt !== 16'd45) begin bad++; $display("FAIL sw_t q=%h rise=%h cnt=%0d exp=3d/01/45", bus_a.q, bus_a.rise, bus_a.toggle_cnt); end
    bus_a.mode = JK_MODE_D; bus_a.j = 8'hC3; bus_a.k = 8'hFF;
    tick;
    total++; if (bus_a.q !== 8'hC3 || bus_a.q_n !== 8'h3C || bus_a.toggle_cnt !== 16'd52) begin bad++; $display("FAIL sw_d2 q=%h qn=%h cnt=%0d exp=c3/3c/52", bus_a.q, bus_a.q_n, bus_a.toggle_cnt); end
  endtask

  task automatic test_reset_pulse;
    idle_a; bus_a.en = 1'b1; bus_a.mode = JK_MODE_SR; bus_a.j = 8'h02; bus_a.k = 8'h02;
    tick;
    total++; if (bus_a.sr_conflict !== 1'b1 || bus_a.q !== 8'hC3) begin bad++; $display("FAIL rp_setup sr=%b q=%h exp=1/c3", bus_a.sr_conflict, bus_a.q); end
    #2 reset = 1'b1;
    #1;
    total++; if (bus_a.q !== 8'hA5 || bus_a.q_n !== 8'h5A || bus_a.sr_conflict !== 1'b0 || bus_a.toggle_cnt !== 16'd0 || bus_a.rise !== 8'h00 || bus_a.fall !== 8'h00) begin bad++; $display("FAIL rp_async q=%h qn=%h sr=%b cnt=%0d rise=%h fall=%h exp=a5/5a/0/0/00/00", bus_a.q, bus_a.q_n, bus_a.sr_conflict, bus_a.toggle_cnt, bus_a.rise, bus_a.fall); end
    reset = 1'b0;
    idle_a; bus_a.en = 1'b1; bus_a.mode = JK_MODE_T; bus_a.j = 8'h0F;
    tick;
    total++; if (bus_a.q !== 8'hAA || bus_a.rise !== 8'h0A || bus_a.fall !== 8'h05 || bus_a.toggle_cnt !== 16'd4) begin bad++; $display("FAIL rp_after q=%h rise=%h fall=%h cnt=%0d exp=aa/0a/05/4", bus_a.q, bus_a.rise, bus_a.fall, bus_a.toggle_cnt); end
  endtask

  task automatic test_saturate;
    bus_b.en = 1'b1; bus_b.mode = JK_MODE_T; bus_b.j = 8'hFF; bus_b.k = 8'h00; bus_b.cnt_clr = 1'b0;
    tick;
    total++; if (bus_b.q !== 8'hFF || bus_b.toggle_cnt !== 4'd8) begin bad++; $display("FAIL sat_8 q=%h cnt=%0d exp=ff/8", bus_b.q, bus_b.toggle_cnt); end
    tick;
    total++; if (bus_b.q !== 8'h00 || bus_b.toggle_cnt !== 4'd15) begin bad++; $display("FAIL sat_clamp q=%h cnt=%0d exp=00/15", bus_b.q, bus_b.toggle_cnt); end
    tick;
    total++; if (bus_b.q !== 8'hFF || bus_b.toggle_cnt !== 4'd15) begin bad++; $display("FAIL sat_stay q=%h cnt=%0d exp=ff/15", bus_b.q, bus_b.toggle_cnt); end
    bus_b.cnt_clr = 1'b1;
    tick;
    total++; if (bus_b.q !== 8'h00 || bus_b.toggle_cnt !== 4'd0 || bus_b.fall !== 8'hFF) begin bad++; $display("FAIL sat_clr q=%h cnt=%0d fall=%h exp=00/0/ff", bus_b.q, bus_b.toggle_cnt, bus_b.fall); end
    bus_b.cnt_clr = 1'b0; bus_b.j = 8'h07;
    tick;
    total++; if (bus_b.q !== 8'h07 || bus_b.toggle_cnt !== 4'd3) begin bad++; $display("FAIL sat_resume q=%h cnt=%0d exp=07/3", bus_b.q, bus_b.toggle_cnt); end
    bus_b.en = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset;
    test_jk;
    test_sr;
    test_priority;
    test_mode_switch;
    test_reset_pulse;
    test_saturate;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
